// File: rtl/imm_gen_pipe.sv
// Decodes RV instructions into an XLEN-bit sign-extended immediate and a format code.
// Latency: 1 cycle from accepted instruction to head of the output buffer.
// Backpressure: a 2-entry skid buffer makes in_ready depend only on registered state.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output logic [2:0]       imm_fmt,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   head_imm_q, head_imm_d;
    logic [XLEN-1:0]   tail_imm_q, tail_imm_d;
    logic [2:0]        head_fmt_q, head_fmt_d;
    logic [2:0]        tail_fmt_q, tail_fmt_d;
    logic [CNT_W-1:0]  ill_q, ill_d;

    logic [31:0]       dec_imm32;
    logic [XLEN-1:0]   dec_imm;
    logic [2:0]        dec_fmt;
    logic              push;
    logic              pop;

    // Handshake signals are functions of registered state only, so there is no
    // combinational path from out_ready to in_ready or from in_* to out_*.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The head entry persists after a pop to EMPTY, which gives the
    // "last popped value" view while the buffer is idle.
    assign imm_data  = head_imm_q;
    assign imm_fmt   = head_fmt_q;
    assign ill_count = ill_q;

    // Opcode decode: build a 32-bit sign-extended field, then widen to XLEN.
    always_comb begin
        dec_fmt   = FMT_ILL;
        dec_imm32 = 32'd0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                dec_fmt   = FMT_R;
                dec_imm32 = 32'd0;
            end
            default: begin
                dec_fmt   = FMT_ILL;
                dec_imm32 = 32'd0;
            end
        endcase
        dec_imm = XLEN'($signed(dec_imm32));
    end

    // Skid-buffer next state: head is always the oldest entry, tail the second.
    always_comb begin
        state_d    = state_q;
        head_imm_d = head_imm_q;
        head_fmt_d = head_fmt_q;
        tail_imm_d = tail_imm_q;
        tail_fmt_d = tail_fmt_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_imm_d = dec_imm;
                    head_fmt_d = dec_fmt;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    // Outgoing head is consumed; the new entry replaces it.
                    head_imm_d = dec_imm;
                    head_fmt_d = dec_fmt;
                end else if (push) begin
                    tail_imm_d = dec_imm;
                    tail_fmt_d = dec_fmt;
                    state_d    = ST_FULL;
                end else if (pop) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_imm_d = tail_imm_q;
                    head_fmt_d = tail_fmt_q;
                    state_d    = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Illegal-opcode counter counts at acceptance and saturates at all ones.
    always_comb begin
        ill_d = ill_q;
        if (push && (dec_fmt == FMT_ILL) && (ill_q != {CNT_W{1'b1}})) begin
            ill_d = ill_q + CNT_W'(1);
        end
    end

    // State and data registers; reset discards any buffered entries.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            head_imm_q <= '0;
            head_fmt_q <= '0;
            tail_imm_q <= '0;
            tail_fmt_q <= '0;
            ill_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_imm_q <= head_imm_d;
            head_fmt_q <= head_fmt_d;
            tail_imm_q <= tail_imm_d;
            tail_fmt_q <= tail_fmt_d;
            ill_q      <= ill_d;
        end
    end

endmodule
